// File: rtl/ram_pkg.sv
// Shared constants for the 8x8 single-port RAM and the FIFO controller in front of it.
package ram_pkg;

   localparam int unsigned DATA_W = 8;
   localparam int unsigned ADDR_W = 3;
   localparam int unsigned DEPTH  = 2 ** ADDR_W;

endpackage

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller driving a single-port synchronous RAM, with a one-entry output register.
// A prefetch read always wins the RAM port over a write in the same cycle.
module ram_fifo_ctrl #(
   parameter int unsigned DATA_W = ram_pkg::DATA_W,
   parameter int unsigned ADDR_W = ram_pkg::ADDR_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [ADDR_W:0]   level,
   output logic              ram_en,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata
);

   localparam int unsigned   DEPTH    = 2 ** ADDR_W;
   localparam int unsigned   CNT_W    = ADDR_W + 1;
   localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
   localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic [CNT_W-1:0]  mem_cnt;
   logic              rd_pend;
   logic              rd_go;
   logic              wr_go;

   // Port arbitration: prefetch only when the output path is completely idle.
   always_comb begin
      rd_go    = !flush && (mem_cnt != '0) && !rd_pend && !out_valid;
      in_ready = rst_n && !flush && (mem_cnt != CNT_FULL) && !rd_go;
      wr_go    = in_valid && in_ready;
   end

   always_comb begin
      ram_en    = rd_go || wr_go;
      ram_we    = wr_go;
      ram_addr  = rd_go ? rd_ptr : wr_ptr;
      ram_wdata = in_data;
   end

   // Occupancy counts the RAM, the read in flight and the output register.
   always_comb begin
      level = mem_cnt + CNT_W'(rd_pend) + CNT_W'(out_valid);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         mem_cnt   <= '0;
         rd_pend   <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (flush) begin
         // out_data is deliberately left untouched; out_valid hides it.
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         mem_cnt   <= '0;
         rd_pend   <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         if (wr_go) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (rd_go) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         if (wr_go && !rd_go) begin
            mem_cnt <= mem_cnt + CNT_ONE;
         end else if (rd_go && !wr_go) begin
            mem_cnt <= mem_cnt - CNT_ONE;
         end
         rd_pend <= rd_go;
         if (rd_pend) begin
            out_data  <= ram_rdata;
            out_valid <= 1'b1;
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Bench for ram_fifo_ctrl with a behavioural 8x8 RAM, a cycle-vector table and a data scoreboard.
module tb_ram_fifo_ctrl;

   localparam int unsigned DATA_W = 8;
   localparam int unsigned ADDR_W = 3;

   logic              clk;
   logic              rst_n;
   logic              flush;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [ADDR_W:0]   level;
   logic              ram_en;
   logic              ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_wdata;
   logic [DATA_W-1:0] ram_rdata;

   ram_fifo_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .level     (level),
      .ram_en    (ram_en),
      .ram_we    (ram_we),
      .ram_addr  (ram_addr),
      .ram_wdata (ram_wdata),
      .ram_rdata (ram_rdata)
   );

   // Behavioural single-port RAM: registered read, valid the cycle after en && !we.
   logic [DATA_W-1:0] ram_mem [8];
   always @(posedge clk) begin
      if (ram_en) begin
         if (ram_we) ram_mem[ram_addr] <= ram_wdata;
         else        ram_rdata <= ram_mem[ram_addr];
      end
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   int checks = 0;
   int errors = 0;
   int pops   = 0;
   int max_lvl = 0;
   logic [DATA_W-1:0] exp_q[$];

   typedef struct {
      int iv; int id; int ordy;
      int ir; int en; int we; int addr; int ov; int lvl;
   } vec_t;
   vec_t vt[20];

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got=%0d expected=%0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Scoreboard: called once per cycle at the falling edge.
   task automatic sb_sample();
      logic [DATA_W-1:0] e;
      if (!rst_n || flush) begin
         exp_q.delete();
         return;
      end
      if (int'(level) > max_lvl) max_lvl = int'(level);
      if (in_valid && in_ready) exp_q.push_back(in_data);
      if (out_valid && out_ready) begin
         pops++;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_underflow got=%0d expected=none", out_data);
         end else begin
            e = exp_q.pop_front();
            chk("sb_data", int'(out_data), int'(e));
         end
      end
   endtask

   task automatic cyc_a();
      @(negedge clk);
   endtask

   task automatic cyc_b();
      sb_sample();
      @(posedge clk);
      #1;
   endtask

   task automatic step();
      cyc_a();
      cyc_b();
   endtask

   task automatic drain(input string nm);
      int n;
      n = 0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      while ((level != 0 || exp_q.size() != 0) && n < 100) begin
         step();
         n++;
      end
      chk({nm, "_level"}, int'(level), 0);
      chk({nm, "_queue"}, exp_q.size(), 0);
      out_ready = 1'b0;
   endtask

   // Offer consecutive values starting at first until cnt are accepted (bounded).
   task automatic push_n(input string nm, input int first, input int cnt);
      int acc;
      int n;
      acc = 0;
      n = 0;
      while (acc < cnt && n < 60) begin
         in_valid = 1'b1;
         in_data  = 8'(first + acc);
         cyc_a();
         if (in_ready) acc++;
         cyc_b();
         n++;
      end
      in_valid = 1'b0;
      chk({nm, "_accepted"}, acc, cnt);
   endtask

   // Run until a prefetch-read cycle is seen; returns with that edge just taken.
   task automatic find_read(input string nm);
      int  n;
      bit  found;
      n = 0;
      found = 1'b0;
      while (!found && n < 10) begin
         cyc_a();
         found = ram_en && !ram_we;
         cyc_b();
         n++;
      end
      chk({nm, "_read_seen"}, int'(found), 1);
   endtask

   initial begin
      int nxt, acc, p0, n;

      vt[0]  = '{1, 42, 0, 1, 1, 1, 0, 0, 0};
      vt[1]  = '{0,  0, 0, 0, 1, 0, 0, 0, 1};
      vt[2]  = '{0,  0, 0, 1, 0, 0, 1, 0, 1};
      vt[3]  = '{0,  0, 1, 1, 0, 0, 1, 1, 1};
      vt[4]  = '{0,  0, 0, 1, 0, 0, 1, 0, 0};
      vt[5]  = '{1, 10, 0, 1, 1, 1, 1, 0, 0};
      vt[6]  = '{1, 11, 0, 0, 1, 0, 1, 0, 1};
      vt[7]  = '{1, 11, 0, 1, 1, 1, 2, 0, 1};
      vt[8]  = '{1, 12, 0, 1, 1, 1, 3, 1, 2};
      vt[9]  = '{0,  0, 1, 1, 0, 0, 4, 1, 3};
      vt[10] = '{1, 13, 0, 0, 1, 0, 2, 0, 2};
      vt[11] = '{1, 13, 0, 1, 1, 1, 4, 0, 2};
      vt[12] = '{0,  0, 1, 1, 0, 0, 5, 1, 3};
      vt[13] = '{0,  0, 0, 0, 1, 0, 3, 0, 2};
      vt[14] = '{0,  0, 0, 1, 0, 0, 5, 0, 2};
      vt[15] = '{0,  0, 1, 1, 0, 0, 5, 1, 2};
      vt[16] = '{0,  0, 0, 0, 1, 0, 4, 0, 1};
      vt[17] = '{0,  0, 0, 1, 0, 0, 5, 0, 1};
      vt[18] = '{0,  0, 1, 1, 0, 0, 5, 1, 1};
      vt[19] = '{0,  0, 0, 1, 0, 0, 5, 0, 0};

      rst_n     = 1'b0;
      flush     = 1'b0;
      in_valid  = 1'b1;
      in_data   = 8'd0;
      out_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready", int'(in_ready), 0);
      chk("rst_ram_en", int'(ram_en), 0);
      chk("rst_level", int'(level), 0);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_out_data", int'(out_data), 0);
      @(posedge clk);
      #1;
      rst_n    = 1'b1;
      in_valid = 1'b0;

      // Single word, pop, then read/write port conflicts, one row per cycle.
      for (int i = 0; i < 20; i++) begin
         in_valid  = vt[i].iv[0];
         in_data   = 8'(vt[i].id);
         out_ready = vt[i].ordy[0];
         cyc_a();
         chk($sformatf("v%0d_in_ready", i), int'(in_ready), vt[i].ir);
         chk($sformatf("v%0d_ram_en", i), int'(ram_en), vt[i].en);
         chk($sformatf("v%0d_ram_we", i), int'(ram_we), vt[i].we);
         if (vt[i].en != 0 || vt[i].iv == 0)
            chk($sformatf("v%0d_ram_addr", i), int'(ram_addr), vt[i].addr);
         chk($sformatf("v%0d_out_valid", i), int'(out_valid), vt[i].ov);
         chk($sformatf("v%0d_level", i), int'(level), vt[i].lvl);
         cyc_b();
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;

      // Reset asserted while a read is in flight with level 3.
      push_n("rstseq", 50, 4);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      find_read("rstseq");
      chk("rstseq_pre_level", int'(level), 3);
      in_valid = 1'b1;
      rst_n    = 1'b0;
      #1;
      chk("rstseq_out_valid", int'(out_valid), 0);
      chk("rstseq_out_data", int'(out_data), 0);
      chk("rstseq_level", int'(level), 0);
      chk("rstseq_ram_en", int'(ram_en), 0);
      chk("rstseq_ram_we", int'(ram_we), 0);
      chk("rstseq_ram_addr", int'(ram_addr), 0);
      chk("rstseq_in_ready", int'(in_ready), 0);
      exp_q.delete();
      @(posedge clk);
      #1;
      rst_n    = 1'b1;
      in_valid = 1'b0;
      cyc_a();
      chk("rstseq_rel_in_ready", int'(in_ready), 1);
      chk("rstseq_rel_level", int'(level), 0);
      chk("rstseq_rel_ram_en", int'(ram_en), 0);
      cyc_b();

      // Full: offer 1..12 with the consumer stalled.
      out_ready = 1'b0;
      nxt = 1;
      acc = 0;
      for (int c = 0; c < 30; c++) begin
         in_valid = (nxt <= 12);
         in_data  = 8'(nxt);
         cyc_a();
         if (in_valid && in_ready) begin
            acc++;
            nxt++;
         end
         cyc_b();
      end
      in_valid = 1'b0;
      cyc_a();
      chk("full_accepted", acc, 9);
      chk("full_level", int'(level), 9);
      chk("full_in_ready", int'(in_ready), 0);
      cyc_b();
      p0 = pops;
      drain("full_drain");
      chk("full_pops", pops - p0, 9);

      // Wrap: 20 words with the consumer always ready.
      max_lvl   = 0;
      out_ready = 1'b1;
      nxt = 0;
      n   = 0;
      p0  = pops;
      while ((pops - p0) < 20 && n < 300) begin
         in_valid = (nxt < 20);
         in_data  = 8'(nxt);
         cyc_a();
         if (in_valid && in_ready) nxt++;
         cyc_b();
         n++;
      end
      in_valid = 1'b0;
      chk("wrap_pops", pops - p0, 20);
      chk("wrap_level_le9", int'(max_lvl <= 9), 1);
      drain("wrap_drain");

      // Flush while a read is in flight and mem_cnt is 4.
      push_n("flush", 100, 6);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      find_read("flush");
      flush = 1'b1;
      cyc_a();
      chk("flush_pre_level", int'(level), 5);
      chk("flush_in_ready", int'(in_ready), 0);
      chk("flush_ram_en", int'(ram_en), 0);
      cyc_b();
      flush = 1'b0;
      for (int c = 0; c < 3; c++) begin
         cyc_a();
         chk($sformatf("flush_post%0d_out_valid", c), int'(out_valid), 0);
         chk($sformatf("flush_post%0d_level", c), int'(level), 0);
         cyc_b();
      end
      in_valid = 1'b1;
      in_data  = 8'd7;
      cyc_a();
      chk("flush_push_ram_we", int'(ram_en && ram_we), 1);
      chk("flush_push_addr", int'(ram_addr), 0);
      cyc_b();
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 10) begin
         step();
         n++;
      end
      chk("flush_push_out_valid", int'(out_valid), 1);
      chk("flush_push_out_data", int'(out_data), 7);
      drain("flush_drain");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ram_fifo_ctrl.md
Name: ram_fifo_ctrl

Overview:
FIFO controller that sits directly upstream of the 8x8 single-port synchronous ram block. It owns that RAM's en/we/addres/data_in pins and consumes its data_out.
- Producer side: valid/ready push stream.
- Consumer side: valid/ready pop stream, fed from a one-entry output register.
- Single RAM port: a prefetch read and a write never share a cycle; the read wins.

Parameters:
DATA_W, 8, data width; must equal the RAM word width
ADDR_W, 3, RAM address width
DEPTH, 2**ADDR_W, derived localparam (not overridable); number of RAM entries

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous clear of all contents
in_valid  input  1  producer has data
in_ready  output  1  controller accepts in_data this cycle
in_data  input  DATA_W  push data
out_valid  output  1  out_data holds the oldest entry
out_ready  input  1  consumer takes out_data this cycle
out_data  output  DATA_W  pop data
level  output  ADDR_W+1  total entries held, 0..DEPTH+1
ram_en  output  1  to ram en
ram_we  output  1  to ram we
ram_addr  output  ADDR_W  to ram addres
ram_wdata  output  DATA_W  to ram data_in
ram_rdata  input  DATA_W  from ram data_out

Behaviour:
- RAM contract: on a clk edge with en=1 and we=1, the RAM writes data_in at addres. On a clk edge with en=1 and we=0, it registers mem[addres] onto data_out, so the word is valid in the following cycle.
- State:
  - wr_ptr, rd_ptr: ADDR_W bits each; wrap DEPTH-1 -> 0 by natural overflow.
  - mem_cnt: 0..DEPTH.
  - rd_pend: 1 bit.
  - out_valid / out_data: output register.
- Combinational decisions:
  - rd_go = !flush && mem_cnt!=0 && !rd_pend && !out_valid.
  - in_ready = !flush && mem_cnt!=DEPTH && !rd_go.
  - wr_go = in_valid && in_ready.
  - No combinational path from out_ready or in_valid to in_ready.
- RAM drive:
  - ram_en = rd_go|wr_go.
  - ram_we = wr_go.
  - ram_addr = rd_go ? rd_ptr : wr_ptr.
  - ram_wdata = in_data.
- Per edge:
  - wr_go: wr_ptr++.
  - rd_go: rd_ptr++ and rd_pend<=1.
  - mem_cnt += wr_go - rd_go.
  - rd_pend=1: out_data<=ram_rdata, out_valid<=1, rd_pend<=0. out_valid is always 0 when rd_pend=1.
  - out_valid && out_ready: out_valid<=0.
- level = mem_cnt + rd_pend + out_valid, registered-equivalent (function of state only).
- Latency:
  - A word accepted in cycle t is read in t+1 if the output path is idle.
  - ram_rdata is valid in t+2.
  - out_valid=1 in t+3.
- Sustained pop rate: one word per 3 cycles. This is accepted by design.
- Write landing in cycle t and read of the same address in t+1 returns the new data; no bypass is needed.
- Full: mem_cnt==DEPTH forces in_ready=0. Total capacity is DEPTH+1, i.e. level==9 at defaults.
- Empty: out_valid=0; out_ready is ignored.
- flush=1 (priority over everything):
  - in_ready=0, ram_en=0.
  - Next edge: pointers, mem_cnt, rd_pend, out_valid <= 0.
  - A read in flight is discarded.
  - out_data holds its value.
- Reset (rst_n=0, any time, including mid-read):
  - All state 0, out_data=0, out_valid=0, level=0, ram_en=ram_we=0, ram_addr=0.
  - in_ready=0 while rst_n=0 (gated); 1 in the first cycle after release.
  - RAM contents are not cleared; they are simply unreachable.

Decomposition:
- Shared package ram_pkg: DATA_W=8, ADDR_W=3, and localparam DEPTH. The ram block uses the same constants.
- No sub-module: the pointer/count logic is small enough to live inline.

Test Plan:
- Reset: assert rst_n=0 during rd_pend=1 with level=3 -> all outputs 0 immediately; after release, in_ready=1, level=0, ram_en=0.
- Single word: push 42 in cycle t ->
  - t: ram_en=1, ram_we=1, ram_addr=0.
  - t+1: ram_en=1, ram_we=0, ram_addr=0.
  - t+3: out_valid=1, out_data=42, level=1.
  - Pop in t+3 -> out_valid=0 and level=0 in t+4.
- Full: out_ready=0, push 1..12 continuously -> exactly 9 accepted (1..9), level=9, in_ready=0 held. Popping then yields 1..9 in order.
- Wrap: push 0..19 while popping whenever out_valid -> output sequence is exactly 0..19. Pointers pass 7->0 at least twice; level never exceeds 9.
- Read/write conflict: mem_cnt=2, out_valid=0, in_valid=1 -> in_ready=0 and a read (ram_we=0) that cycle; the write is accepted the next cycle.
- Flush: assert flush for 1 cycle while rd_pend=1 and mem_cnt=4 -> next cycle level=0, out_valid=0, and the returning ram_rdata is never presented. A subsequent push of 7 appears as out_data=7, written at addr 0.
